inst_queue: RTL and testbench

//   Instruction queue between instruction fetch and decode/Imm_Gen.

---
 rtl/inst_queue.sv | 144 ++++++++++++++
 tb/tb_inst_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between instruction fetch and decode/Imm_Gen.
//   Holds up to DEPTH {pc, inst, imm_sel} entries in a circular buffer with
//   valid/ready handshakes on both sides. The ImmSel code is pre-decoded from
//   the opcode when an entry is written, so decode can drive Imm_Gen straight
//   from the queue head. A synchronous flush empties the queue on redirects.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   in_valid     in   fetch presents an instruction
//   in_ready     out  queue can accept (count < DEPTH)
//   in_pc        in   PC of incoming instruction
//   in_inst      in   incoming instruction word
//   flush        in   discard all entries (highest priority)
//   out_valid    out  head entry valid (count != 0)
//   out_ready    in   decode consumes the head entry
//   out_pc       out  PC of head entry
//   out_inst     out  instruction of head entry
//   out_imm_sel  out  pre-decoded ImmSel of head entry
//   count        out  number of valid entries
// ----------------------------------------------------------------------------
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [31:0]                in_inst,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [31:0]                out_inst,
   output logic [2:0]                 out_imm_sel,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Opcode -> ImmSel encoding consumed by Imm_Gen; 3'b111 means "no immediate".
   function automatic logic [2:0] predecode(input logic [6:0] opcode);
      logic [2:0] sel;
      case (opcode)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: sel = 3'b000; // I
         7'b0100011:                                     sel = 3'b001; // S
         7'b1100011:                                     sel = 3'b010; // B
         7'b1101111:                                     sel = 3'b011; // J
         7'b0110111, 7'b0010111:                         sel = 3'b100; // U
         default:                                        sel = 3'b111; // R-type / illegal
      endcase
      return sel;
   endfunction

   logic [PC_W-1:0] pc_mem_r   [DEPTH];
   logic [31:0]     inst_mem_r [DEPTH];
   logic [2:0]      sel_mem_r  [DEPTH];

   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic [AW-1:0]   wr_ptr_nxt_s;
   logic [AW-1:0]   rd_ptr_nxt_s;
   logic [CW-1:0]   count_nxt_s;
   logic            push_s;
   logic            pop_s;

   // Handshake flags depend only on the registered count, never on the peer's valid/ready.
   assign in_ready  = (count_r < CW'(DEPTH));
   assign out_valid = (count_r != '0);
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;

   assign out_pc      = pc_mem_r[rd_ptr_r];
   assign out_inst    = inst_mem_r[rd_ptr_r];
   assign out_imm_sel = sel_mem_r[rd_ptr_r];
   assign count       = count_r;

   // Next pointer/count values; flush overrides any push or pop in the same cycle.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      count_nxt_s  = count_r;
      if (flush) begin
         wr_ptr_nxt_s = '0;
         rd_ptr_nxt_s = '0;
         count_nxt_s  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= count_nxt_s;
      end
   end

   // Entry storage; reset fills every slot with a NOP so the head reads a benign value.
   // Flush deliberately leaves the contents alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= '0;
            inst_mem_r[i] <= NOP_INST;
            sel_mem_r[i]  <= 3'b000;
         end
      end else if (push_s && !flush) begin
         pc_mem_r[wr_ptr_r]   <= in_pc;
         inst_mem_r[wr_ptr_r] <= in_inst;
         sel_mem_r[wr_ptr_r]  <= predecode(in_inst[6:0]);
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_queue
//   Self-checking bench for inst_queue: directed scenarios followed by a
//   randomized run, all compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk;
   logic              clk_en;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [31:0]       in_inst;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [31:0]       out_inst;
   logic [2:0]        out_imm_sel;
   logic [2:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: each element is {pc, inst}
   logic [63:0] model_q[$];

   inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .out_imm_sel(out_imm_sel), .count(count)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // ImmSel expected for an instruction, straight from the opcode table
   function automatic logic [2:0] exp_sel(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      if (op inside {7'h03, 7'h13, 7'h67, 7'h73}) return 3'b000;
      else if (op == 7'h23) return 3'b001;
      else if (op == 7'h63) return 3'b010;
      else if (op == 7'h6F) return 3'b011;
      else if (op inside {7'h37, 7'h17}) return 3'b100;
      else return 3'b111;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // compare every visible output against the model
   task automatic check_state(input string tag);
      int sz;
      sz = model_q.size();
      check({tag, " count"},     64'(count),     64'(sz));
      check({tag, " out_valid"}, 64'(out_valid), 64'(sz != 0));
      check({tag, " in_ready"},  64'(in_ready),  64'(sz < DEPTH));
      if (sz != 0) begin
         check({tag, " out_pc"},      64'(out_pc),      64'(model_q[0][63:32]));
         check({tag, " out_inst"},    64'(out_inst),    64'(model_q[0][31:0]));
         check({tag, " out_imm_sel"}, 64'(out_imm_sel), 64'(exp_sel(model_q[0][31:0])));
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
   endtask

   // one clock edge: advance the model with the held inputs, then check outputs
   task automatic tick(input string tag);
      int  sz;
      bit  do_push;
      bit  do_pop;
      @(posedge clk);
      sz = model_q.size();
      if (flush) begin
         model_q.delete();
      end else begin
         do_push = in_valid && (sz < DEPTH);
         do_pop  = out_ready && (sz > 0);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({in_pc, in_inst});
      end
      #1;
      check_state(tag);
   endtask

   logic [31:0] ops [11] = '{32'h03, 32'h13, 32'h67, 32'h73, 32'h23, 32'h63,
                             32'h6F, 32'h37, 32'h17, 32'h33, 32'h7F};

   initial begin
      logic [31:0] r;
      logic [31:0] inst;
      clk_en = 1'b0;
      rst    = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // 1. reset without clock
      #3;
      check("reset out_valid",   64'(out_valid),   64'(0));
      check("reset in_ready",    64'(in_ready),    64'(1));
      check("reset count",       64'(count),       64'(0));
      check("reset out_pc",      64'(out_pc),      64'(0));
      check("reset out_inst",    64'(out_inst),    64'(NOP));
      check("reset out_imm_sel", 64'(out_imm_sel), 64'(3'b000));
      #4;
      rst    = 1'b0;
      clk_en = 1'b1;

      // 2. single push of addi
      drive(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
      tick("push addi");
      check("addi out_inst", 64'(out_inst),    64'(32'h0050_0093));
      check("addi imm_sel",  64'(out_imm_sel), 64'(3'b000));
      check("addi count",    64'(count),       64'(1));

      // 3. drain addi, then fill to DEPTH with out_ready low
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick("drain addi");
      drive(1'b1, 32'h4, 32'h0011_2223, 1'b0, 1'b0);  tick("fill sw");
      drive(1'b1, 32'h8, 32'h0000_0463, 1'b0, 1'b0);  tick("fill beq");
      drive(1'b1, 32'hC, 32'h0080_00EF, 1'b0, 1'b0);  tick("fill jal");
      drive(1'b1, 32'h10, 32'h1234_50B7, 1'b0, 1'b0); tick("fill lui");
      check("full count",    64'(count),    64'(4));
      check("full in_ready", 64'(in_ready), 64'(0));
      drive(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
      tick("fifth push ignored");
      check("ignored count", 64'(count),       64'(4));
      check("head sw sel",   64'(out_imm_sel), 64'(3'b001));
      drive(1'b1, 32'h104, 32'h0000_0013, 1'b1, 1'b0);  // pop while full; push still blocked
      tick("pop when full");
      check("head beq sel",  64'(out_imm_sel), 64'(3'b010));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick("drain beq");
      check("head jal sel",  64'(out_imm_sel), 64'(3'b011));
      tick("drain jal");
      check("head lui sel",  64'(out_imm_sel), 64'(3'b100));
      tick("drain lui");
      check("drained count", 64'(count), 64'(0));

      // 4. steady state of two entries with push & pop every cycle
      drive(1'b1, 32'h200, 32'h0020_81B3, 1'b0, 1'b0);
      tick("prefill add");
      check("add imm_sel", 64'(out_imm_sel), 64'(3'b111));
      drive(1'b1, 32'h204, 32'h0050_0093, 1'b0, 1'b0);
      tick("prefill addi");
      for (int i = 0; i < 10; i++) begin
         r = $urandom();
         inst = (i % 2 == 0) ? 32'h0020_81B3 : {r[31:7], ops[i % 11][6:0]};
         drive(1'b1, 32'h208 + 32'(i * 4), inst, 1'b1, 1'b0);
         tick("steady");
         check("steady count", 64'(count), 64'(2));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick("steady drain1");
      tick("steady drain2");

      // 5. flush with simultaneous push and pop
      drive(1'b1, 32'h400, 32'h0000_0463, 1'b0, 1'b0); tick("pre-flush 1");
      drive(1'b1, 32'h404, 32'h0011_2223, 1'b0, 1'b0); tick("pre-flush 2");
      drive(1'b1, 32'h408, 32'h0080_00EF, 1'b0, 1'b0); tick("pre-flush 3");
      drive(1'b1, 32'hDEAD0, 32'h1234_50B7, 1'b1, 1'b1);
      tick("flush");
      check("flush count",     64'(count),     64'(0));
      check("flush out_valid", 64'(out_valid), 64'(0));
      check("flush in_ready",  64'(in_ready),  64'(1));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick("post-flush idle1");
      tick("post-flush idle2");
      drive(1'b1, 32'h500, 32'h0050_0093, 1'b0, 1'b0);
      tick("post-flush push");
      check("post-flush out_pc", 64'(out_pc), 64'(32'h500));

      // 6. asynchronous reset between edges with two entries held
      drive(1'b1, 32'h600, 32'h0000_0463, 1'b0, 1'b0); tick("pre-rst 1");
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("pre-rst count", 64'(count), 64'(2));
      #2;
      rst = 1'b1;
      #1;
      model_q.delete();
      check("async rst count",     64'(count),     64'(0));
      check("async rst out_valid", 64'(out_valid), 64'(0));
      check("async rst in_ready",  64'(in_ready),  64'(1));
      check("async rst out_inst",  64'(out_inst),  64'(NOP));
      check("async rst out_pc",    64'(out_pc),    64'(0));
      #1;
      rst = 1'b0;
      drive(1'b1, 32'h700, 32'h1234_50B7, 1'b0, 1'b0);
      tick("post-rst push");
      check("post-rst out_pc",  64'(out_pc),      64'(32'h700));
      check("post-rst imm_sel", 64'(out_imm_sel), 64'(3'b100));

      // 7. randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r    = $urandom();
         inst = {r[31:7], ops[$urandom_range(0, 10)][6:0]};
         drive(($urandom_range(0, 3) != 0), $urandom(), inst,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         // handshake flags must not react to the new inputs before the edge
         #1;
         check("rand no-comb in_ready",  64'(in_ready),  64'(model_q.size() < DEPTH));
         check("rand no-comb out_valid", 64'(out_valid), 64'(model_q.size() != 0));
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
